sram_bist_master: RTL and testbench
===================================

// Module: sram_bist_master
// PURPOSE
//  Initiator for the SRAM valid/ready request interface (addr, wdata, write, valid -> ready, error, rdata).
//  On start: writes pattern (addr+1) to every word 0..DEPTH-1, then reads all words back and compares.
//  Reports pass/fail, first failing address/data and a saturating error count.
//  Sits between system control logic and the RAM macro; replaces bench-driven fill/readback.
// PARAMETERS
//  ADDR_W   16    request address width
//  DATA_W   16    data width
//  DEPTH    2048  words exercised; addresses 0..DEPTH-1; DEPTH <= 2**ADDR_W
//  TIMEOUT  16    max cycles a request may wait for ready before abort; >= 2
//  ERRCNT_W 8     error counter width, saturating
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous active-low reset
//  start      in   1       1-cycle pulse; begins a test from IDLE or DONE
//  busy       out  1       test in progress
//  done       out  1       test finished; held until next start
//  pass       out  1       valid with done; 1 = no mismatch, no error, no timeout
//  timeout    out  1       a request exceeded TIMEOUT cycles
//  fail_addr  out  ADDR_W  address of first mismatch/error
//  fail_data  out  DATA_W  rdata returned at fail_addr (0 if failure was error/timeout)
//  err_cnt    out  ERRCNT_W mismatches + error responses, saturating at all-ones
//  m_addr     out  ADDR_W  request address
//  m_wdata    out  DATA_W  write data
//  m_write    out  1       1 = write, 0 = read
//  m_valid    out  1       request valid
//  m_ready    in   1       responder completes request in this cycle
//  m_error    in   1       responder error, sampled only when m_ready=1
//  m_rdata    in   DATA_W  read data, sampled only when m_valid&m_ready&~m_write
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; all outputs 0; m_valid drops immediately. Reset mid-test aborts, no done.
//  Handshake: m_addr/m_wdata/m_write held stable while m_valid=1 until a rising edge with m_ready=1.
//   Transfer = m_valid&m_ready at that edge. Next request presented the following cycle (1 idle cycle min
//   not required: back-to-back allowed). m_valid never withdrawn without ready except by reset/timeout.
//  FSM: IDLE -start-> WR; WR: addr steps 0..DEPTH-1, m_wdata=(addr+1) mod 2**DATA_W;
//   after last write transfer -> RD; RD: addr steps 0..DEPTH-1, compare m_rdata to (addr+1) mod 2**DATA_W;
//   after last read transfer -> DONE (or INV phases, see CONFIGURATION). DONE -start-> WR.
//  start ignored while busy. start in DONE clears pass/timeout/fail_*/err_cnt and restarts.
//  Mismatch or m_error=1 on a transfer: err_cnt+1 (saturate); first one captures fail_addr/fail_data.
//   Errors do not stop the test.
//  Wait counter reloads each new request; TIMEOUT cycles with m_valid=1 and m_ready=0 -> m_valid=0,
//   timeout=1, fail_addr=current addr if no earlier failure, go DONE.
//  busy=1 in WR/RD/INV states; done=1 only in DONE; pass = done & err_cnt==0 & ~timeout.
//  Address counter is ADDR_W wide; last-address detect uses DEPTH-1, never wraps past it.
// CONFIGURATION
//  SRAM_BIST_INV_PASS_EN defined: after RD, phases WRI then RDI repeat the sweep with data ~((addr+1));
//   DONE after RDI; errors accumulate across all phases.
//  Undefined: RD -> DONE directly; WRI/RDI states absent.
// STRUCTURE
//  Shared package sram_pkg: FSM state encoding (IDLE, WR, RD, WRI, RDI, DONE), pattern function
//   pat(addr, inv), default widths.
//  Sub-module sram_bist_checker: compare, m_error fold-in, saturating err_cnt, first-fail capture.
// TESTING
//  Ideal RAM model ready every cycle, DEPTH=2048: start -> 4096 transfers, done, pass=1, err_cnt=0.
//  Model corrupts word 5 (returns 0): done, pass=0, fail_addr=5, fail_data=0, err_cnt=1.
//  Model holds ready=0 at addr 100 write: after 16 cycles m_valid=0, timeout=1, fail_addr=100, pass=0.
//  Random ready stalls (0..5 cycles): m_addr/m_wdata stable while stalled; pass=1.
//  rst=0 mid-RD at addr 700: outputs 0 same cycle; new start runs full test, pass=1.
//  m_error=1 on every read of addr 3 and 9; ERRCNT_W=1: err_cnt saturates at 1, fail_addr=3.

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared FSM encoding, default widths and test pattern for the SRAM BIST master
package sram_pkg;

   // Test sequencing states; WRI/RDI are only reachable with SRAM_BIST_INV_PASS_EN
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      RD   = 3'd2,
      WRI  = 3'd3,
      RDI  = 3'd4,
      DONE = 3'd5
   } state_t;

   localparam int DEF_ADDR_W   = 16;
   localparam int DEF_DATA_W   = 16;
   localparam int DEF_DEPTH    = 2048;
   localparam int DEF_TIMEOUT  = 16;
   localparam int DEF_ERRCNT_W = 8;

   // Pattern is computed at this width and truncated by the caller to its data width
   localparam int PAT_W = 32;

   // Word stored at addr: addr+1, bitwise inverted for the inverted sweep
   function automatic logic [PAT_W-1:0] pat(input logic [PAT_W-1:0] addr, input logic inv);
      logic [PAT_W-1:0] p;
      p = addr + PAT_W'(1);
      return inv ? ~p : p;
   endfunction

endpackage

// File: rtl/sram_bist_checker.sv
// rtl/sram_bist_checker.sv - read compare, error fold-in, saturating error count, first-fail capture
import sram_pkg::*;

module sram_bist_checker #(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ERRCNT_W = DEF_ERRCNT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                rd_xfer,
   input  logic                any_xfer,
   input  logic                error,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [DATA_W-1:0]   expected,
   input  logic [ADDR_W-1:0]   addr,
   input  logic                tmo,
   output logic [ADDR_W-1:0]   fail_addr,
   output logic [DATA_W-1:0]   fail_data,
   output logic [ERRCNT_W-1:0] err_cnt
);

   logic have_fail;
   logic mismatch;
   logic bad;

   // A faulty transfer is counted once, whether it mismatched, errored, or both
   assign mismatch = rd_xfer & (rdata != expected);
   assign bad      = mismatch | (any_xfer & error);

   // Saturating error counter and capture of the first failure (error/timeout records zero data)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         have_fail <= 1'b0;
         fail_addr <= '0;
         fail_data <= '0;
         err_cnt   <= '0;
      end else if (clear) begin
         have_fail <= 1'b0;
         fail_addr <= '0;
         fail_data <= '0;
         err_cnt   <= '0;
      end else begin
         if (bad && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERRCNT_W'(1);
         end
         if (bad && !have_fail) begin
            have_fail <= 1'b1;
            fail_addr <= addr;
            fail_data <= error ? '0 : rdata;
         end else if (tmo && !have_fail) begin
            have_fail <= 1'b1;
            fail_addr <= addr;
            fail_data <= '0;
         end
      end
   end

endmodule

// File: rtl/sram_bist_master.sv
// rtl/sram_bist_master.sv - SRAM BIST initiator (fill + readback), inverted pass under SRAM_BIST_INV_PASS_EN
import sram_pkg::*;

module sram_bist_master #(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int TIMEOUT  = DEF_TIMEOUT,
   parameter int ERRCNT_W = DEF_ERRCNT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic                timeout,
   output logic [ADDR_W-1:0]   fail_addr,
   output logic [DATA_W-1:0]   fail_data,
   output logic [ERRCNT_W-1:0] err_cnt,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic                m_write,
   output logic                m_valid,
   input  logic                m_ready,
   input  logic                m_error,
   input  logic [DATA_W-1:0]   m_rdata
);

   // Wait counter holds 0..TIMEOUT-1 stalled cycles of the current request
   localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT - 1);

   state_t             state_q, state_d, phase_next;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic               timeout_q, timeout_d;
   logic               active, write_ph, inv_ph, clear;
   logic               tmo_hit;
   logic [DATA_W-1:0]  exp_data;

`ifdef SRAM_BIST_INV_PASS_EN
   assign active   = (state_q == WR) || (state_q == RD) || (state_q == WRI) || (state_q == RDI);
   assign write_ph = (state_q == WR) || (state_q == WRI);
   assign inv_ph   = (state_q == WRI) || (state_q == RDI);
`else
   assign active   = (state_q == WR) || (state_q == RD);
   assign write_ph = (state_q == WR);
   assign inv_ph   = 1'b0;
`endif

   assign clear    = start && ((state_q == IDLE) || (state_q == DONE));
   assign tmo_hit  = active && !m_ready && (wait_q == WAIT_MAX);
   assign exp_data = DATA_W'(pat(PAT_W'(addr_q), inv_ph));

   // Request outputs are forced to zero whenever no request is outstanding
   assign m_valid = active;
   assign m_write = write_ph;
   assign m_addr  = active ? addr_q : '0;
   assign m_wdata = write_ph ? exp_data : '0;
   assign busy    = active;
   assign done    = (state_q == DONE);
   assign timeout = timeout_q;
   assign pass    = done && (err_cnt == '0) && !timeout_q;

   // Phase that follows the last transfer of the current sweep
   always_comb begin
      phase_next = DONE;
      case (state_q)
         WR:      phase_next = RD;
`ifdef SRAM_BIST_INV_PASS_EN
         RD:      phase_next = WRI;
         WRI:     phase_next = RDI;
`endif
         default: phase_next = DONE;
      endcase
   end

   // Next-state: address stepping, stall counting and timeout abort
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wait_d    = wait_q;
      timeout_d = timeout_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = WR;
               addr_d    = '0;
               wait_d    = '0;
               timeout_d = 1'b0;
            end
         end
`ifdef SRAM_BIST_INV_PASS_EN
         WR, RD, WRI, RDI: begin
`else
         WR, RD: begin
`endif
            if (m_ready) begin
               wait_d = '0;
               if (addr_q == LAST_ADDR) begin
                  addr_d  = '0;
                  state_d = phase_next;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end else if (tmo_hit) begin
               state_d   = DONE;
               timeout_d = 1'b1;
               wait_d    = '0;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset drops the request immediately and abandons any test
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
      end
   end

   sram_bist_checker #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .ERRCNT_W (ERRCNT_W)
   ) u_checker (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .rd_xfer   (active && m_ready && !write_ph),
      .any_xfer  (active && m_ready),
      .error     (m_error),
      .rdata     (m_rdata),
      .expected  (exp_data),
      .addr      (addr_q),
      .tmo       (tmo_hit),
      .fail_addr (fail_addr),
      .fail_data (fail_data),
      .err_cnt   (err_cnt)
   );

endmodule

// File: tb/tb_sram_bist_master.sv
// tb/tb_sram_bist_master.sv - self-checking bench for sram_bist_master with a behavioural RAM responder
module tb_sram_bist_master;

   localparam int AW     = 16;
   localparam int DW     = 16;
   localparam int DEPTH  = 2048;
   localparam int TMO    = 16;
   localparam int EW     = 8;
   localparam int DEPTH2 = 16;
`ifdef SRAM_BIST_INV_PASS_EN
   localparam int NPH = 4;
`else
   localparam int NPH = 2;
`endif

   typedef struct {
      int rnd;
      int corrupt;
      int hold;
      int e_pass;
      int e_tmo;
      int e_fa;
      int e_fd;
      int e_cnt;
      int e_xfer;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b0, start = 1'b0, start2 = 1'b0;
   logic          busy, done, pass, timeout, m_write, m_valid;
   logic [AW-1:0] fail_addr, m_addr;
   logic [DW-1:0] fail_data, m_wdata;
   logic [EW-1:0] err_cnt;
   logic          m_ready = 1'b0, m_error = 1'b0;
   logic [DW-1:0] m_rdata = '0;

   logic          busy2, done2, pass2, timeout2, m_write2, m_valid2, m_error2;
   logic          m_ready2;
   logic [AW-1:0] fail_addr2, m_addr2;
   logic [DW-1:0] fail_data2, m_wdata2, m_rdata2;
   logic [0:0]    err_cnt2;
   logic [DW-1:0] mem2 [0:DEPTH2-1];

   int total = 0;
   int bad   = 0;

   int rand_mode = 0, corrupt_addr = -1, hold_addr = -1;
   int xfer_cnt = 0, seq_err = 0, stab_err = 0, hold_cnt = 0;
   int model_err = 0, model_have = 0, model_fa = 0, model_fd = 0;
   int stall_left = 0;
   bit need_new = 1'b1;
   logic [DW-1:0] mem [0:DEPTH-1];
   logic          pv = 1'b0, pr = 1'b0, pw = 1'b0, perr = 1'b0;
   logic [AW-1:0] pa = '0;
   logic [DW-1:0] pd = '0, prd = '0;

   sram_bist_master #(
      .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TMO), .ERRCNT_W(EW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
      .timeout(timeout), .fail_addr(fail_addr), .fail_data(fail_data), .err_cnt(err_cnt),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_write(m_write), .m_valid(m_valid),
      .m_ready(m_ready), .m_error(m_error), .m_rdata(m_rdata)
   );

   sram_bist_master #(
      .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH2), .TIMEOUT(TMO), .ERRCNT_W(1)
   ) dut2 (
      .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
      .timeout(timeout2), .fail_addr(fail_addr2), .fail_data(fail_data2), .err_cnt(err_cnt2),
      .m_addr(m_addr2), .m_wdata(m_wdata2), .m_write(m_write2), .m_valid(m_valid2),
      .m_ready(m_ready2), .m_error(m_error2), .m_rdata(m_rdata2)
   );

   // Second responder: always ready, ideal storage, error on every read of words 3 and 9
   assign m_ready2 = 1'b1;
   assign m_rdata2 = mem2[m_addr2[3:0]];
   assign m_error2 = m_valid2 && !m_write2 && ((m_addr2 == 3) || (m_addr2 == 9));

   always @(posedge clk) begin
      if (m_valid2 && m_ready2 && m_write2) mem2[m_addr2[3:0]] <= m_wdata2;
   end

   function automatic logic [DW-1:0] want(input int a, input bit inv);
      logic [DW-1:0] p;
      p = DW'(a + 1);
      return inv ? ~p : p;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Responder + monitor: retires the transfer of the previous edge, then drives this cycle
   always @(negedge clk) begin
      int k, ph, a;
      bit ew;
      logic [DW-1:0] ed;
      if (!rst) begin
         pv = 1'b0; pr = 1'b0; need_new = 1'b1; stall_left = 0;
         m_ready = 1'b0; m_error = 1'b0; m_rdata = '0;
      end else begin
         if (pv && pr) begin
            k  = xfer_cnt;
            ph = k / DEPTH;
            a  = k % DEPTH;
            ew = (ph % 2) == 0;
            ed = want(a, ph >= 2);
            if (ph >= NPH || int'(pa) != a || pw != ew || (ew && pd != ed)) seq_err++;
            if (pw) begin
               mem[pa] = pd;
            end else if (prd != ed || perr) begin
               if (model_err < (1 << EW) - 1) model_err++;
               if (model_have == 0) begin
                  model_have = 1;
                  model_fa   = int'(pa);
                  model_fd   = perr ? 0 : int'(prd);
               end
            end
            xfer_cnt++;
            need_new = 1'b1;
         end
         if (pv && !pr && m_valid && (m_addr != pa || m_wdata != pd || m_write != pw)) stab_err++;
         if (m_valid && m_write && int'(m_addr) == hold_addr) hold_cnt++;
         if (!m_valid) begin
            need_new = 1'b1;
         end else if (need_new) begin
            stall_left = (rand_mode != 0) ? int'($urandom_range(0, 5)) : 0;
            need_new   = 1'b0;
         end
         m_ready = m_valid && (stall_left == 0) && !(m_write && int'(m_addr) == hold_addr);
         if (stall_left > 0) stall_left--;
         m_rdata = (int'(m_addr) == corrupt_addr) ? '0 : mem[m_addr];
         m_error = 1'b0;
         pv = m_valid; pr = m_ready; pa = m_addr; pw = m_write; pd = m_wdata;
         prd = m_rdata; perr = m_error;
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_scn(input vec_t v, input string nm);
      int n;
      rand_mode = v.rnd; corrupt_addr = v.corrupt; hold_addr = v.hold;
      xfer_cnt = 0; seq_err = 0; stab_err = 0; hold_cnt = 0;
      model_err = 0; model_have = 0; model_fa = 0; model_fd = 0;
      pulse_start();
      n = 0;
      while (!done && n < 60000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      #1;
      check({nm, "_done"},      done, 1);
      check({nm, "_busy"},      busy, 0);
      check({nm, "_valid"},     m_valid, 0);
      check({nm, "_pass"},      pass, v.e_pass);
      check({nm, "_timeout"},   timeout, v.e_tmo);
      check({nm, "_fail_addr"}, fail_addr, v.e_fa);
      check({nm, "_fail_data"}, fail_data, v.e_fd);
      check({nm, "_err_cnt"},   err_cnt, v.e_cnt);
      check({nm, "_xfers"},     xfer_cnt, v.e_xfer);
      check({nm, "_sequence"},  seq_err, 0);
      check({nm, "_stable"},    stab_err, 0);
      check({nm, "_model_cnt"}, err_cnt, model_err);
      if (v.e_tmo == 0) begin
         check({nm, "_model_fa"}, fail_addr, model_fa);
         check({nm, "_model_fd"}, fail_data, model_fd);
      end
      if (v.hold >= 0) check({nm, "_stall_cycles"}, hold_cnt, TMO);
   endtask

   initial begin
      vec_t tbl [4];
      int n;
      tbl[0] = '{0, -1,  -1, 1, 0,   0, 0, 0,       NPH * DEPTH};
      tbl[1] = '{0,  5,  -1, 0, 0,   5, 0, NPH / 2, NPH * DEPTH};
      tbl[2] = '{0, -1, 100, 0, 1, 100, 0, 0,       100};
      tbl[3] = '{1, -1,  -1, 1, 0,   0, 0, 0,       NPH * DEPTH};
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;

      repeat (3) @(negedge clk);
      #1;
      check("reset_ctrl", {busy, done, pass, timeout, m_valid, m_write}, 0);
      check("reset_addr", m_addr, 0);
      check("reset_fail", {fail_addr, fail_data, err_cnt}, 0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 4; i++) run_scn(tbl[i], $sformatf("vec%0d", i));

      // Reset in the middle of the read sweep, then a clean full run
      rand_mode = 0; corrupt_addr = -1; hold_addr = -1;
      pulse_start();
      n = 0;
      while (!(m_valid && !m_write && m_addr == 700) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("mid_rd_reached", m_valid && !m_write && m_addr == 700, 1);
      rst = 1'b0;
      #1;
      check("mid_rst_ctrl", {m_valid, m_write, busy, done, pass, timeout}, 0);
      check("mid_rst_bus", {m_addr, m_wdata, err_cnt}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_scn(tbl[0], "post_rst");

      // One-bit error counter saturates; first failure is the error at word 3
      @(negedge clk);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n = 0;
      while (!done2 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      #1;
      check("sat_done", done2, 1);
      check("sat_err_cnt", err_cnt2, 1);
      check("sat_fail_addr", fail_addr2, 3);
      check("sat_fail_data", fail_data2, 0);
      check("sat_pass", pass2, 0);
      check("sat_timeout", timeout2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
